load_ctrl: RTL and testbench
============================

# load_ctrl

Front-end input conditioner that drives the 4-bit loadable counter's `load` and `c_in` inputs from raw board inputs. Synchronizes and debounces a load push-button and four value switches, then issues a single-cycle load pulse with the captured switch value on each debounced press. Holding the button auto-repeats the pulse at a fixed interval.

## Interface
- `DATA_W`, default 4: width of the switch bus and of `c_in`.
- `SYNC_STAGES`, default 2: flip-flop synchronizer depth on `btn_raw` and `sw_raw`; minimum 2.
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles of disagreement needed to flip the debounced state; minimum 1.
- `REPEAT_CYCLES`, default 0: auto-repeat period in cycles while held; 0 disables repeat.

- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `btn_raw`  in  1  asynchronous, bouncy load button; active-high.
- `sw_raw`  in  DATA_W  asynchronous value switches.
- `load`  out  1  registered single-cycle load pulse to the counter.
- `c_in`  out  DATA_W  registered load value; valid in the `load` cycle and held until the next pulse.
- `btn_stable`  out  1  debounced button level.

## Operation
- Synchronizer: `btn_raw` and each `sw_raw` bit pass through a SYNC_STAGES flop chain. Outputs `btn_s` and `sw_s` are the last stage of each chain.
- Debounce counter `db_cnt`:
  - Width is $clog2(DEBOUNCE_CYCLES+1).
  - On any edge where `btn_s == btn_stable`, `db_cnt` clears to 0.
  - On any edge where `btn_s != btn_stable`:
    - If `db_cnt == DEBOUNCE_CYCLES-1`, then `btn_stable <= btn_s` and `db_cnt <= 0`.
    - Otherwise `db_cnt` increments.
  - A single agreeing cycle restarts the count.
- FSM, two states:
  - IDLE (button released):
    - On a `btn_stable` 0->1 transition, go to HELD.
    - Same edge: `load <= 1`, `c_in <= sw_s`, `rpt_cnt <= 0`.
  - HELD (button held):
    - If `btn_stable` becomes 0, go to IDLE. No pulse. `c_in` keeps its value.
    - Else, if REPEAT_CYCLES != 0 and `rpt_cnt == REPEAT_CYCLES-1`: `load <= 1`, `c_in <= sw_s`, `rpt_cnt <= 0`.
    - Else `rpt_cnt` increments, saturating when REPEAT_CYCLES == 0.
- `load` is 0 on every edge not listed above, so it is never high for two consecutive cycles unless REPEAT_CYCLES == 1.
- `rpt_cnt` width is $clog2(REPEAT_CYCLES+1), minimum 1.
- `sw_s` is sampled only in the pulse cycle. Switch changes at any other time have no effect on `c_in`.

## Timing
- Reset: all synchronizer flops, `btn_stable`, `db_cnt`, `rpt_cnt`, `load` and `c_in` go to 0. FSM goes to IDLE. `load` is forced low in the reset cycle.
- Press latency: with `btn_raw` first sampled high at edge E and held clean:
  - `btn_stable` rises at edge E+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - `load` is high for the cycle after edge E+SYNC_STAGES+DEBOUNCE_CYCLES.
  - With SYNC_STAGES=2 and D=4, the `load` edge is E+6.
- `c_in` changes on the same edge that `load` rises.
- Repeat: successive pulses are exactly REPEAT_CYCLES edges apart, measured from the first pulse.
- Release latency: `btn_stable` falls SYNC_STAGES+DEBOUNCE_CYCLES-1 edges after the first low sample. No output pulse on release.
- Bounce: a glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes `btn_stable` and never pulses `load`.
- Reset mid-operation: any pending pulse or count is discarded. If the button is still held after reset releases, a full debounce runs and a fresh pulse follows after the full press latency.
- Simultaneous release and repeat terminal count on the same edge: release wins. Go to IDLE, no pulse.

## Test plan
- Clean press (D=4, R=0, `sw_raw`=0xA, `btn_raw` high from edge 10):
  - Expect one `load` pulse, high in the cycle after edge 16, with `c_in`=0xA.
  - Expect no further pulses while held, and none on release.
- Bounce (D=4): toggle `btn_raw` 1,0,1,0,1 on consecutive cycles, then hold low. Expect `btn_stable`=0 and `load` never asserted.
- Auto-repeat (D=4, R=8):
  - Hold the button for 40 cycles, changing `sw_raw` 0x3->0x5 between pulses.
  - Expect pulses 8 edges apart, the first carrying 0x3 and later ones 0x5.
  - Expect exactly the number of pulses that fit before release is debounced.
- Switch isolation: change `sw_raw` 0x1->0xF while the button is idle. Expect `c_in` to hold its last loaded value and `load`=0.
- Reset mid-hold: assert `rst_n`=0 for 2 cycles while held in HELD.
  - Expect `load`, `c_in` and `btn_stable` = 0 during reset.
  - After release of reset, expect a new pulse 6 edges after the first sample, with the current switch value.
- Release/repeat collision (D=4, R=8): time the release so `btn_stable` falls on the terminal-count edge. Expect no pulse and the FSM in IDLE.

Source files
------------

// File: rtl/load_ctrl.sv
// Load-button front end for the 4-bit counter: synchronizes and debounces the button and switches,
// then issues a one-cycle load pulse carrying the switch value, with optional auto-repeat.
module load_ctrl #(
  parameter int unsigned DATA_W          = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_CYCLES   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_raw,
  input  logic [DATA_W-1:0] sw_raw,
  output logic              load,
  output logic [DATA_W-1:0] c_in,
  output logic              btn_stable
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_W = (REPEAT_CYCLES == 0) ? 1 : $clog2(REPEAT_CYCLES + 1);

  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_SAT = '1;

  typedef enum logic [0:0] {StIdle, StHeld} state_e;

  logic [SYNC_STAGES-1:0]             btn_sync_q;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] sw_sync_q;
  logic                               btn_s;
  logic [DATA_W-1:0]                  sw_s;

  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              btn_stable_q, btn_stable_d;
  state_e            state_q, state_d;
  logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic              load_q, load_d;
  logic [DATA_W-1:0] c_in_q, c_in_d;

  assign btn_s = btn_sync_q[SYNC_STAGES-1];
  assign sw_s  = sw_sync_q[SYNC_STAGES-1];

  // Any agreeing sample restarts the count; D disagreeing samples in a row flip the level.
  always_comb begin
    db_cnt_d     = '0;
    btn_stable_d = btn_stable_q;
    if (btn_s != btn_stable_q) begin
      if (db_cnt_q == DB_MAX) begin
        btn_stable_d = btn_s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Press is seen one edge after btn_stable rises; release acts on the edge it falls, so a
  // release coinciding with the repeat terminal count suppresses that pulse.
  always_comb begin
    state_d   = state_q;
    load_d    = 1'b0;
    c_in_d    = c_in_q;
    rpt_cnt_d = rpt_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (btn_stable_q) begin
          state_d   = StHeld;
          load_d    = 1'b1;
          c_in_d    = sw_s;
          rpt_cnt_d = '0;
        end
      end
      StHeld: begin
        if (!btn_stable_d) begin
          state_d = StIdle;
        end else if (REPEAT_CYCLES != 0 && rpt_cnt_q == RPT_MAX) begin
          load_d    = 1'b1;
          c_in_d    = sw_s;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q != RPT_SAT) begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_sync_q   <= '0;
      sw_sync_q    <= '0;
      db_cnt_q     <= '0;
      btn_stable_q <= 1'b0;
      state_q      <= StIdle;
      rpt_cnt_q    <= '0;
      load_q       <= 1'b0;
      c_in_q       <= '0;
    end else begin
      btn_sync_q   <= {btn_sync_q[SYNC_STAGES-2:0], btn_raw};
      sw_sync_q    <= {sw_sync_q[SYNC_STAGES-2:0], sw_raw};
      db_cnt_q     <= db_cnt_d;
      btn_stable_q <= btn_stable_d;
      state_q      <= state_d;
      rpt_cnt_q    <= rpt_cnt_d;
      load_q       <= load_d;
      c_in_q       <= c_in_d;
    end
  end

  assign load       = load_q;
  assign c_in       = c_in_q;
  assign btn_stable = btn_stable_q;

endmodule

// File: tb/tb_load_ctrl.sv
// Bench for load_ctrl: two instances (no repeat, repeat every 8) share inputs; a timestamp-based
// reference model feeds per-instance scoreboards, and a monitor checks every cycle.
module tb_load_ctrl;

  localparam int S  = 2;
  localparam int D  = 4;
  localparam int R0 = 0;
  localparam int R1 = 8;

  typedef struct packed {
    int unsigned k;
    logic [3:0]  c;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       btn_raw;
  logic [3:0] sw_raw;
  logic       load0, load8, st0, st8;
  logic [3:0] c_in0, c_in8;

  load_ctrl #(.DATA_W(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R0)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .sw_raw     (sw_raw),
    .load       (load0),
    .c_in       (c_in0),
    .btn_stable (st0)
  );

  load_ctrl #(.DATA_W(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R1)) u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .sw_raw     (sw_raw),
    .load       (load8),
    .c_in       (c_in8),
    .btn_stable (st8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned edge_cnt = 0;
  logic        smp_rst  = 1'b0;
  logic        smp_btn  = 1'b0;
  logic [3:0]  smp_sw   = '0;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    smp_rst  <= rst_n;
    smp_btn  <= btn_raw;
    smp_sw   <= sw_raw;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Reference model state
  exp_t        q0[$];
  exp_t        q1[$];
  logic        hist_b [S];
  logic [3:0]  hist_s [S];
  logic        m_stable;
  int          m_run;
  logic        m_held [2];
  logic [3:0]  m_c [2];
  int unsigned m_last [2];

  // Model: inputs reach the debouncer S edges after sampling; the stable level flips after D
  // consecutive disagreeing samples; pulses fire on press, then every R edges since the last one.
  initial begin : model
    int unsigned k;
    logic        bs, st_old, pulse;
    logic [3:0]  ss;
    int          rpt;
    forever begin
      @(negedge clk);
      k = edge_cnt;
      if (!smp_rst) begin
        for (int i = 0; i < S; i++) begin
          hist_b[i] = 1'b0;
          hist_s[i] = '0;
        end
        m_stable = 1'b0;
        m_run    = 0;
        for (int m = 0; m < 2; m++) begin
          m_held[m] = 1'b0;
          m_c[m]    = '0;
          m_last[m] = 0;
        end
      end else begin
        bs     = hist_b[S-1];
        ss     = hist_s[S-1];
        st_old = m_stable;
        if (bs != m_stable) begin
          m_run++;
          if (m_run == D) begin
            m_stable = bs;
            m_run    = 0;
          end
        end else begin
          m_run = 0;
        end
        for (int m = 0; m < 2; m++) begin
          rpt   = (m == 0) ? R0 : R1;
          pulse = 1'b0;
          if (!m_held[m]) begin
            if (st_old) begin
              m_held[m] = 1'b1;
              pulse     = 1'b1;
            end
          end else if (!m_stable) begin
            m_held[m] = 1'b0;
          end else if (rpt != 0 && int'(k - m_last[m]) == rpt) begin
            pulse = 1'b1;
          end
          if (pulse) begin
            m_c[m]    = ss;
            m_last[m] = k;
            if (m == 0) q0.push_back('{k: k, c: ss});
            else        q1.push_back('{k: k, c: ss});
          end
        end
        for (int i = S - 1; i > 0; i--) begin
          hist_b[i] = hist_b[i-1];
          hist_s[i] = hist_s[i-1];
        end
        hist_b[0] = smp_btn;
        hist_s[0] = smp_sw;
      end
    end
  end

  // Pulse log per instance, filled by the monitor
  int          pulse_cnt [2];
  int unsigned pk [2][64];
  logic [3:0]  pcv [2][64];

  initial begin : monitor
    logic       ld, st, have, exp_ld;
    logic [3:0] ci;
    exp_t       fe;
    pulse_cnt[0] = 0;
    pulse_cnt[1] = 0;
    forever begin
      @(negedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
        ld   = (m == 0) ? load0 : load8;
        ci   = (m == 0) ? c_in0 : c_in8;
        st   = (m == 0) ? st0 : st8;
        have = (m == 0) ? (q0.size() != 0) : (q1.size() != 0);
        fe   = '0;
        if (have) fe = (m == 0) ? q0[0] : q1[0];
        exp_ld = have && (fe.k == edge_cnt);
        check((m == 0) ? "d0 btn_stable" : "d8 btn_stable", int'(st), int'(m_stable));
        check((m == 0) ? "d0 c_in" : "d8 c_in", int'(ci), int'(m_c[m]));
        check((m == 0) ? "d0 load" : "d8 load", int'(ld), int'(exp_ld));
        if (exp_ld) begin
          if (m == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
          if (ld) check((m == 0) ? "d0 pulse c_in" : "d8 pulse c_in", int'(ci), int'(fe.c));
        end
        if (ld) begin
          pk[m][pulse_cnt[m] % 64]  = edge_cnt;
          pcv[m][pulse_cnt[m] % 64] = ci;
          pulse_cnt[m]++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin : stim
    int          p0, p8, len;
    int unsigned e;
    rst_n   = 1'b0;
    btn_raw = 1'b0;
    sw_raw  = '0;
    tick(3);
    check("reset load", int'(load0), 0);
    check("reset c_in", int'(c_in8), 0);
    rst_n = 1'b1;

    // Clean press: first sampled at edge 10, pulse after edge 16
    sw_raw = 4'hA;
    tick(6);
    p0 = pulse_cnt[0];
    e  = edge_cnt + 1;
    check("press sample edge", int'(e), 10);
    btn_raw = 1'b1;
    tick(30);
    check("press pulse count", pulse_cnt[0] - p0, 1);
    check("press pulse edge", int'(pk[0][p0 % 64]), 16);
    check("press pulse c_in", int'(pcv[0][p0 % 64]), 'hA);
    btn_raw = 1'b0;
    tick(20);
    check("release no pulse", pulse_cnt[0] - p0, 1);
    check("release stable", int'(st0), 0);

    // Bounce shorter than the debounce window
    p0 = pulse_cnt[0];
    p8 = pulse_cnt[1];
    for (int i = 0; i < 5; i++) begin
      btn_raw = ~i[0];
      tick(1);
    end
    btn_raw = 1'b0;
    tick(15);
    check("bounce d0 pulses", pulse_cnt[0] - p0, 0);
    check("bounce d8 pulses", pulse_cnt[1] - p8, 0);
    check("bounce stable", int'(st8), 0);

    // Auto-repeat: 40 held cycles, switches 3 -> 5 between pulses
    sw_raw = 4'h3;
    tick(3);
    p8 = pulse_cnt[1];
    e  = edge_cnt + 1;
    btn_raw = 1'b1;
    tick(10);
    sw_raw = 4'h5;
    tick(30);
    btn_raw = 1'b0;
    tick(20);
    check("repeat pulse count", pulse_cnt[1] - p8, 5);
    check("repeat first edge", int'(pk[1][p8 % 64] - e), 6);
    check("repeat first c_in", int'(pcv[1][p8 % 64]), 3);
    for (int i = 1; i < 5; i++) begin
      check("repeat spacing", int'(pk[1][(p8 + i) % 64] - pk[1][(p8 + i - 1) % 64]), R1);
      check("repeat later c_in", int'(pcv[1][(p8 + i) % 64]), 5);
    end

    // Switch isolation while idle
    p8 = pulse_cnt[1];
    sw_raw = 4'h1;
    tick(5);
    sw_raw = 4'hF;
    tick(5);
    check("isolation c_in", int'(c_in8), 5);
    check("isolation pulses", pulse_cnt[1] - p8, 0);

    // Reset mid-hold
    sw_raw  = 4'h7;
    btn_raw = 1'b1;
    tick(12);
    sw_raw = 4'h9;
    tick(3);
    rst_n = 1'b0;
    tick(2);
    check("mid reset load", int'(load0), 0);
    check("mid reset c_in", int'(c_in0), 0);
    check("mid reset stable", int'(st0), 0);
    rst_n = 1'b1;
    p0 = pulse_cnt[0];
    e  = edge_cnt + 1;
    tick(12);
    check("post reset pulses", pulse_cnt[0] - p0, 1);
    check("post reset edge", int'(pk[0][p0 % 64] - e), 6);
    check("post reset c_in", int'(pcv[0][p0 % 64]), 9);
    btn_raw = 1'b0;
    tick(20);

    // Release debounced on the repeat terminal-count edge
    sw_raw = 4'h2;
    tick(3);
    p8 = pulse_cnt[1];
    e  = edge_cnt + 1;
    btn_raw = 1'b1;
    tick(17);
    btn_raw = 1'b0;
    tick(20);
    check("collision pulses", pulse_cnt[1] - p8, 2);
    p8 = pulse_cnt[1];
    e  = edge_cnt + 1;
    btn_raw = 1'b1;
    tick(10);
    check("collision re-press", pulse_cnt[1] - p8, 1);
    check("collision re-press edge", int'(pk[1][p8 % 64] - e), 6);
    btn_raw = 1'b0;
    tick(20);

    // Randomized segments with occasional resets
    for (int seg = 0; seg < 60; seg++) begin
      btn_raw = 1'($urandom_range(0, 1));
      len     = int'($urandom_range(1, 25));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) sw_raw = 4'($urandom);
        tick(1);
      end
      if ($urandom_range(0, 14) == 0) begin
        rst_n = 1'b0;
        tick(int'($urandom_range(1, 2)));
        rst_n = 1'b1;
      end
    end
    btn_raw = 1'b0;
    tick(20);

    check("d0 scoreboard drained", q0.size(), 0);
    check("d8 scoreboard drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
